rggen_adapter_buffered: RTL

Registered, timeout-guarded successor to the common bus-to-register adapter, sitting between a protocol front end (APB/AXI4-Lite/Avalon bridge) and the register array of an rggen block. It captures each bus request into a request register, drives it to the register array, waits for a response, and returns a registered bus response. It adds optional address-range pre-decode, a programmable response timeout that converts a hung register access into an error, and a timeout event output.

---
 rtl/rggen_adapter_buffered_if.sv | 28 ++
 rtl/rggen_adapter_buffered.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rggen_adapter_buffered_if.sv
// Bus-side request/response bundle for rggen_adapter_buffered.
//   master : protocol front end, which drives the request and receives the response
//   slave  : the adapter, which receives the request and drives the response
// Request : valid, access[1:0], address, write_data, strobe
// Response: ready (one-cycle pulse), status[1:0], read_data
interface rggen_adapter_buffered_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    logic                     valid;
    logic [1:0]               access;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   strobe;
    logic                     ready;
    logic [1:0]               status;
    logic [BUS_WIDTH-1:0]     read_data;

    modport master (
        output valid, access, address, write_data, strobe,
        input  ready, status, read_data
    );

    modport slave (
        input  valid, access, address, write_data, strobe,
        output ready, status, read_data
    );
endinterface

// File: rtl/rggen_adapter_buffered.sv
// Registered, timeout-guarded bus-to-register adapter for an rggen register block.
// A bus request is captured into a request register, presented to the register
// array until a slice responds (or no slice decodes, or the wait times out), and
// answered with a one-cycle registered bus response.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   bus_if (slave)          bus request in / registered bus response out
//   o_register_valid        request strobe to the register array (high in ACCESS)
//   o_register_access       captured access type
//   o_register_address      captured address, made local to the block
//   o_register_write_data   captured write data
//   o_register_strobe       captured byte strobes
//   i_register_active       per-slice address hit
//   i_register_ready        per-slice ready
//   i_register_status       per-slice status, 2 bits each
//   i_register_read_data    per-slice read data, BUS_WIDTH bits each
//   o_timeout               one-cycle pulse in the cycle a timeout response is chosen
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a bus request; request captured on i_bus valid
// ACCESS   | request presented to the register array, waiting for a slice
// RESPONSE | registered response presented to the bus for one cycle
module rggen_adapter_buffered #(
    parameter int                     ADDRESS_WIDTH       = 8,
    parameter int                     LOCAL_ADDRESS_WIDTH = 8,
    parameter int                     BUS_WIDTH           = 32,
    parameter int                     REGISTERS           = 1,
    parameter int                     PRE_DECODE          = 0,
    parameter bit [ADDRESS_WIDTH-1:0] BASE_ADDRESS        = '0,
    parameter int                     BYTE_SIZE           = 256,
    parameter int                     ERROR_STATUS        = 0,
    parameter bit [BUS_WIDTH-1:0]     DEFAULT_READ_DATA   = '0,
    parameter int                     TIMEOUT_CYCLES      = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    rggen_adapter_buffered_if.slave        bus_if,
    output logic                           o_register_valid,
    output logic [1:0]                     o_register_access,
    output logic [LOCAL_ADDRESS_WIDTH-1:0] o_register_address,
    output logic [BUS_WIDTH-1:0]           o_register_write_data,
    output logic [BUS_WIDTH/8-1:0]         o_register_strobe,
    input  logic [REGISTERS-1:0]           i_register_active,
    input  logic [REGISTERS-1:0]           i_register_ready,
    input  logic [2*REGISTERS-1:0]         i_register_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data,
    output logic                           o_timeout
);

    localparam int STROBE_WIDTH     = BUS_WIDTH / 8;
    localparam int COUNT_WIDTH      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TIMEOUT_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST   = COUNT_WIDTH'(TIMEOUT_LAST_INT);
    localparam logic [1:0]             DEFAULT_STATUS = (ERROR_STATUS != 0) ? 2'b10 : 2'b00;
    localparam logic [1:0]             TIMEOUT_STATUS = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_RESPONSE = 2'd2
    } state_t;

    state_t                   state;
    logic [COUNT_WIDTH-1:0]   wait_count;
    logic                     bus_ready;
    logic [1:0]               bus_status;
    logic [BUS_WIDTH-1:0]     bus_read_data;

    logic                           in_range;
    logic [LOCAL_ADDRESS_WIDTH-1:0] local_address;
    logic [1:0]                     mux_status;
    logic [BUS_WIDTH-1:0]           mux_read_data;
    logic                           timeout_hit;
    logic                           access_done;
    logic [1:0]                     access_status;
    logic [BUS_WIDTH-1:0]           access_read_data;

    assign bus_if.ready     = bus_ready;
    assign bus_if.status    = bus_status;
    assign bus_if.read_data = bus_read_data;

    // Address range pre-decode; bounds are computed one bit wider so that a
    // block ending at the top of the address space does not wrap.
    generate
        if (PRE_DECODE == 0) begin : g_no_pre_decode
            assign in_range = 1'b1;
        end else begin : g_pre_decode
            localparam logic [ADDRESS_WIDTH:0] RANGE_LOW  = {1'b0, BASE_ADDRESS};
            localparam logic [ADDRESS_WIDTH:0] RANGE_HIGH =
                RANGE_LOW + (ADDRESS_WIDTH + 1)'(BYTE_SIZE - 1);
            logic [ADDRESS_WIDTH:0] address_ext;
            assign address_ext = {1'b0, bus_if.address};
            assign in_range    = (address_ext >= RANGE_LOW) && (address_ext <= RANGE_HIGH);
        end
    endgenerate

    // An aligned base contributes nothing to the low bits, so the subtractor
    // is only built when the base has nonzero bits inside the local window.
    generate
        if (BASE_ADDRESS[LOCAL_ADDRESS_WIDTH-1:0] == '0) begin : g_aligned_base
            assign local_address = bus_if.address[LOCAL_ADDRESS_WIDTH-1:0];
        end else begin : g_offset_base
            logic [ADDRESS_WIDTH-1:0] offset_address;
            assign offset_address = bus_if.address - BASE_ADDRESS;
            assign local_address  = offset_address[LOCAL_ADDRESS_WIDTH-1:0];
        end
    endgenerate

    // Response OR-mux: only active slices contribute.
    always_comb begin
        mux_status    = '0;
        mux_read_data = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            if (i_register_active[i]) begin
                mux_status    = mux_status    | i_register_status[2*i +: 2];
                mux_read_data = mux_read_data | i_register_read_data[BUS_WIDTH*i +: BUS_WIDTH];
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_count == TIMEOUT_LAST);

    // ACCESS completion priority: no slice hit, then slice ready, then timeout.
    always_comb begin
        access_done      = 1'b0;
        access_status    = DEFAULT_STATUS;
        access_read_data = DEFAULT_READ_DATA;
        if (!(|i_register_active)) begin
            access_done = 1'b1;
        end else if (|i_register_ready) begin
            access_done      = 1'b1;
            access_status    = mux_status;
            access_read_data = mux_read_data;
        end else if (timeout_hit) begin
            access_done   = 1'b1;
            access_status = TIMEOUT_STATUS;
        end
    end

    // The timeout pulse marks the decision cycle itself, one cycle ahead of the
    // bus response, so it is decoded from state rather than registered.
    assign o_timeout = (state == ST_ACCESS) && (|i_register_active) &&
                       !(|i_register_ready) && timeout_hit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state                 <= ST_IDLE;
            wait_count            <= '0;
            bus_ready             <= 1'b0;
            bus_status            <= 2'b00;
            bus_read_data         <= '0;
            o_register_valid      <= 1'b0;
            o_register_access     <= 2'b00;
            o_register_address    <= '0;
            o_register_write_data <= '0;
            o_register_strobe     <= '0;
        end else begin
            bus_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus_if.valid) begin
                        o_register_access     <= bus_if.access;
                        o_register_address    <= local_address;
                        o_register_write_data <= bus_if.write_data;
                        o_register_strobe     <= bus_if.strobe[STROBE_WIDTH-1:0];
                        if (in_range) begin
                            state            <= ST_ACCESS;
                            o_register_valid <= 1'b1;
                            wait_count       <= '0;
                        end else begin
                            state         <= ST_RESPONSE;
                            bus_ready     <= 1'b1;
                            bus_status    <= DEFAULT_STATUS;
                            bus_read_data <= DEFAULT_READ_DATA;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (access_done) begin
                        state            <= ST_RESPONSE;
                        o_register_valid <= 1'b0;
                        bus_ready        <= 1'b1;
                        bus_status       <= access_status;
                        bus_read_data    <= access_read_data;
                    end else if (wait_count != '1) begin
                        wait_count <= wait_count + 1'b1;
                    end
                end
                ST_RESPONSE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state            <= ST_IDLE;
                    o_register_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
